// File: rtl/systolic_scheduler.sv
// ---------------------------------------------------------------------------
// systolic_scheduler
//   Sequences one tile matrix-multiply on an ARRAY_SIZE x ARRAY_SIZE systolic
//   array: clears the accumulators, fetches k_len operand slices, drives the
//   skewed per-row valids and the global PE enable, waits out the array
//   drain, then emits one result row per valid/ready handshake.
//
// Ports
//   clk, reset      clock, synchronous active-low reset
//   start, k_len    tile request (sampled in IDLE) and inner-product length
//   busy            high in every state except IDLE
//   acc_clear       1-cycle accumulator clear pulse
//   op_rd_en/idx    operand slice request and its index k
//   op_valid        requested slice present this cycle
//   pe_enable       global PE / delay-line enable
//   row_valid       per-row operand-valid, skewed by one enabled cycle per row
//   res_valid/ready result row handshake, res_row = row index
//   done            1-cycle tile-complete pulse
// ---------------------------------------------------------------------------
module systolic_scheduler #(
  parameter int unsigned ARRAY_SIZE      = 4,
  parameter int unsigned MULTIPLY_CYCLES = 3,
  parameter int unsigned KW              = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [KW-1:0]                 k_len,
  output logic                          busy,
  output logic                          acc_clear,
  output logic                          op_rd_en,
  output logic [KW-1:0]                 op_rd_idx,
  input  logic                          op_valid,
  output logic                          pe_enable,
  output logic [ARRAY_SIZE-1:0]         row_valid,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [$clog2(ARRAY_SIZE)-1:0] res_row,
  output logic                          done
);

  localparam int unsigned RW           = $clog2(ARRAY_SIZE);
  localparam int unsigned DRAIN_CYCLES = 2 * (ARRAY_SIZE - 1) + MULTIPLY_CYCLES;
  localparam int unsigned DW           = $clog2(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    FEED   = 3'd2,
    DRAIN  = 3'd3,
    OUTPUT = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                state;
  logic [KW-1:0]         k_len_q;
  logic [KW-1:0]         k;
  logic [DW-1:0]         drain_cnt;
  logic                  drain_q;
  logic [ARRAY_SIZE-1:1] rv_q;
  logic                  feed_beat;

  // A slice is consumed exactly when it is requested and present.
  assign feed_beat    = op_rd_en & op_valid;
  assign pe_enable    = feed_beat | drain_q;
  assign row_valid    = {rv_q, feed_beat};
  assign op_rd_idx    = k;

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      k_len_q   <= '0;
      k         <= '0;
      drain_cnt <= '0;
      drain_q   <= 1'b0;
      busy      <= 1'b0;
      acc_clear <= 1'b0;
      op_rd_en  <= 1'b0;
      res_valid <= 1'b0;
      res_row   <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            k_len_q   <= k_len;
            state     <= CLEAR;
            busy      <= 1'b1;
            acc_clear <= 1'b1;
          end
        end
        CLEAR: begin
          acc_clear <= 1'b0;
          k         <= '0;
          drain_cnt <= '0;
          res_row   <= '0;
          if (k_len_q == '0) begin
            state     <= OUTPUT;
            res_valid <= 1'b1;
          end else begin
            state    <= FEED;
            op_rd_en <= 1'b1;
          end
        end
        FEED: begin
          if (op_valid) begin
            // k never exceeds k_len_q, so it cannot wrap.
            k <= k + KW'(1);
            if (k == k_len_q - KW'(1)) begin
              state     <= DRAIN;
              op_rd_en  <= 1'b0;
              drain_q   <= 1'b1;
              drain_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
            state     <= OUTPUT;
            drain_q   <= 1'b0;
            res_valid <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        OUTPUT: begin
          if (res_ready) begin
            if (res_row == RW'(ARRAY_SIZE - 1)) begin
              state     <= DONE;
              res_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              res_row <= res_row + RW'(1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Row-valid skew line: advances only with the PE enable so the skew
  // stays aligned with the PE operand delay stages across stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rv_q <= '0;
    end else if (pe_enable) begin
      rv_q[1] <= feed_beat;
      for (int i = 2; i < int'(ARRAY_SIZE); i++) begin
        rv_q[i] <= rv_q[i-1];
      end
    end
  end

endmodule
